// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
// Operation encodings mirror Funct3 so the decoder's bits can be cast directly.
package mdu_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } md_state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// Combinational conditional two's-complement negate; used for operand
// magnitudes on entry and for sign correction of the final result.
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add or restoring divide on
// magnitudes, then one FIX cycle applies the sign and selects the result word.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  import mdu_pkg::*;

  md_state_e         state_q, state_d;
  md_op_e            op_in, op_q;
  logic [4:0]        count_q;
  logic [XLEN-1:0]   a_mag_q, b_mag_q, a_abs, b_abs, result_q, fix_word;
  logic [2*XLEN-1:0] prod_q, mul_next, div_next, fix_in, fix_out;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic              signed_a, signed_b, sign_a, sign_b, neg_q, accept;
  logic              div_zero, div_ovf, div_ok, done_q;

  assign op_in = md_op_e'(Funct3);

  always_comb begin
    signed_a = (op_in != OP_MULHU) && (op_in != OP_DIVU) && (op_in != OP_REMU);
    signed_b = signed_a && (op_in != OP_MULHSU);
    sign_a   = signed_a & SrcA[XLEN-1];
    sign_b   = signed_b & SrcB[XLEN-1];
    div_zero = Funct3[2] && (SrcB == '0);
    div_ovf  = Funct3[2] && !Funct3[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
  end

  mdu_abs_neg #(.W(XLEN)) u_abs_a (.neg(sign_a), .din(SrcA), .dout(a_abs));
  mdu_abs_neg #(.W(XLEN)) u_abs_b (.neg(sign_b), .din(SrcB), .dout(b_abs));

  // Multiply: high half accumulates, low half holds the multiplier and shifts out.
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
  assign mul_next = {mul_sum, prod_q[XLEN-1:1]};

  // Divide: high half is the partial remainder, low half the dividend/quotient.
  assign div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, b_mag_q};
  assign div_ok    = !div_trial[XLEN];
  assign div_next  = {(div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0]),
                      prod_q[XLEN-2:0], div_ok};

  // Products are negated as 64 bits; divide results are negated after word select.
  assign fix_in = op_q[2] ? {{XLEN{1'b0}}, (op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0])}
                          : prod_q;

  mdu_abs_neg #(.W(2*XLEN)) u_fix (.neg(neg_q), .din(fix_in), .dout(fix_out));

  assign fix_word = ((op_q == OP_MUL) || op_q[2]) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !done_q) begin
            accept = 1'b1;
            if (div_zero || div_ovf) state_d = FIX;
            else if (Funct3[2])      state_d = DIV;
            else                     state_d = MUL;
          end
        end
        MUL, DIV: if (count_q == 5'(ITER - 1)) state_d = FIX;
        FIX:      state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      count_q  <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q    <= op_in;
        count_q <= '0;
        a_mag_q <= a_abs;
        b_mag_q <= b_abs;
        if (div_zero) begin
          prod_q <= {SrcA, {XLEN{1'b1}}};
          neg_q  <= 1'b0;
        end else if (div_ovf) begin
          prod_q <= {{XLEN{1'b0}}, SrcA};
          neg_q  <= 1'b0;
        end else begin
          prod_q <= {{XLEN{1'b0}}, (Funct3[2] ? a_abs : b_abs)};
          // Remainder takes the dividend's sign; everything else the XOR.
          neg_q  <= (Funct3[2] && Funct3[1]) ? sign_a : (sign_a ^ sign_b);
        end
      end else if (!flush) begin
        case (state_q)
          MUL: begin
            prod_q  <= mul_next;
            count_q <= count_q + 5'd1;
          end
          DIV: begin
            prod_q  <= div_next;
            count_q <= count_q + 5'd1;
          end
          FIX: begin
            result_q <= fix_word;
            done_q   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy   = (state_q != IDLE) || done_q;
  assign done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected results,
// latency and handshake checks, flush, async reset and ignored-start cases.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        busy, done;
  logic [31:0] Result;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
  );

  always #5 clk = ~clk;

  // Drives one request and watches until done; lat counts cycles after the start edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit busy_ok);
    res = 'x;
    lat = 0;
    busy_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; Funct3 = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    start = 1'b0; SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        res = Result;
        return;
      end
    end
    lat = -1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (Result !== '0)   begin errors++; $display("FAIL reset_result: got %h want 0", Result); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic run_table(input string name, input int n, input logic [2:0] op[8],
                           input logic [31:0] a[8], input logic [31:0] b[8],
                           input logic [31:0] ex[8], input int lt);
    logic [31:0] res, e;
    int lat;
    bit bok;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ex[i]);
      run_op(op[i], a[i], b[i], res, lat, bok);
      e = exp_q.pop_front();
      checks++; if (res !== e) begin errors++; $display("FAIL %s_result[%0d]: got %h want %h", name, i, res, e); end
      checks++; if (lat != lt) begin errors++; $display("FAIL %s_latency[%0d]: got %0d want %0d", name, i, lat, lt); end
      checks++; if (!bok)      begin errors++; $display("FAIL %s_busy[%0d]: busy dropped before done", name, i); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse[%0d]: got %b want 0", name, i, done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after[%0d]: got %b want 0", name, i, busy); end
    end
  endtask

  task automatic test_mul;
    logic [2:0] op[8]; logic [31:0] a[8], b[8], ex[8];
    op = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    a  = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
    ex = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    run_table("mul", 4, op, a, b, ex, 34);
  endtask

  task automatic test_div;
    logic [2:0] op[8]; logic [31:0] a[8], b[8], ex[8];
    op = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000};
    a  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0};
    b  = '{32'd2, 32'd2, 32'd2, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0};
    ex = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
    run_table("div", 4, op, a, b, ex, 34);
  endtask

  task automatic test_special;
    logic [2:0] op[8]; logic [31:0] a[8], b[8], ex[8];
    op = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b110, 3'b000, 3'b000, 3'b000};
    a  = '{32'd55, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FF00, 32'd0, 32'd0, 32'd0};
    b  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    ex = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0, 32'hFFFF_FF00, 32'd0, 32'd0, 32'd0};
    run_table("special", 5, op, a, b, ex, 2);
  endtask

  task automatic test_flush;
    logic [31:0] res, e;
    int lat;
    bit bok;
    exp_q.push_back(32'd30);
    run_op(3'b000, 32'd5, 32'd6, res, lat, bok);
    e = exp_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL flush_prior: got %h want %h", res, e); end
    @(posedge clk); #1;
    start = 1'b1; Funct3 = 3'b000; SrcA = 32'd100; SrcB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL flush_done: got %b want 0", done); end
    checks++; if (Result !== e)   begin errors++; $display("FAIL flush_result_held: got %h want %h", Result, e); end
    exp_q.push_back(32'd81);
    run_op(3'b000, 32'd9, 32'd9, res, lat, bok);
    e = exp_q.pop_front();
    checks++; if (res !== e)  begin errors++; $display("FAIL after_flush_result: got %h want %h", res, e); end
    checks++; if (lat != 34)  begin errors++; $display("FAIL after_flush_latency: got %0d want 34", lat); end
  endtask

  task automatic test_reset_mid;
    bit saw_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; Funct3 = 3'b100; SrcA = 32'd1000; SrcB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL midreset_done: got %b want 0", done); end
    checks++; if (Result !== '0)  begin errors++; $display("FAIL midreset_result: got %h want 0", Result); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL midreset_no_done: got done=1 want none"); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res, e;
    int lat = -1;
    bit bok = 1'b1;
    exp_q.push_back(32'd14);
    @(posedge clk); #1;
    start = 1'b1; Funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    res = 'x;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (!busy) bok = 1'b0;
      if (i == 5) begin start = 1'b1; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd3; end
      if (i == 6) start = 1'b0;
      if (done) begin res = Result; lat = i; break; end
    end
    e = exp_q.pop_front();
    checks++; if (res !== e)  begin errors++; $display("FAIL busy_start_result: got %h want %h", res, e); end
    checks++; if (lat != 34)  begin errors++; $display("FAIL busy_start_latency: got %0d want 34", lat); end
    checks++; if (!bok)       begin errors++; $display("FAIL busy_start_busy: busy dropped before done"); end
    start = 1'b1; Funct3 = 3'b000; SrcA = 32'd2; SrcB = 32'd2;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_cycle_start: busy=%b want 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_cycle_start_late: busy=%b want 0", busy); end
    checks++; if (Result !== e)  begin errors++; $display("FAIL done_cycle_result: got %h want %h", Result, e); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
